// File: rtl/mips_im_loader_pkg.sv
// mips_im_loader_pkg: loader FSM states and instruction-memory geometry shared with the IM block.
package mips_im_loader_pkg;
  localparam int IM_DEPTH  = 256;
  localparam int IM_ADDR_W = 8;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR} state_t;
endpackage

// File: rtl/mips_byte_packer.sv
// mips_byte_packer: big-endian 4-byte shift assembler; o_full flags the push that completes a word.
module mips_byte_packer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);
  logic [23:0] r_word;
  logic [1:0]  r_cnt;
  // o_word already includes the byte being pushed so the 4th byte lands without an extra cycle
  assign o_word = {r_word, i_byte};
  assign o_full = i_push && r_cnt == 2'd3;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset || i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_push) begin
      r_word <= o_word[23:0];
      r_cnt  <= r_cnt + 2'd1;
    end
endmodule

// File: rtl/mips_im_loader.sv
// mips_im_loader: loads LEN / big-endian words / XOR checksum stream into instruction memory,
// holding the CPU in reset until a load completes with a good checksum.
module mips_im_loader
  import mips_im_loader_pkg::*;
#(
  parameter int DEPTH  = IM_DEPTH,
  parameter int ADDR_W = IM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);
  state_t            r_state;
  logic              r_ready, r_we, r_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_cnt, r_n;
  logic [7:0]        r_xor;
  logic              w_acc, w_full;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_nxt;
  assign w_acc     = byte_valid && r_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;
  mips_byte_packer u_packer (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_acc && r_state == LEN),
    .i_push  (w_acc && r_state == DATA),
    .i_byte  (byte_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_xor   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE:
          if (start) begin
            r_state <= LEN;
            r_ready <= 1'b1;
          end
        LEN:
          if (w_acc) begin
            r_n     <= byte_data == 8'd0 ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(byte_data);
            r_waddr <= '0;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_state <= DATA;
          end
        DATA:
          if (w_acc) begin
            r_xor <= r_xor ^ byte_data;
            if (w_full) begin
              r_wdata <= w_word;
              r_we    <= 1'b1;
              r_ready <= 1'b0;
              r_state <= WRITE;
            end
          end
        WRITE: begin
          r_waddr <= r_waddr + 1'b1;
          r_cnt   <= w_cnt_nxt;
          r_ready <= 1'b1;
          r_state <= w_cnt_nxt == r_n ? CHECK : DATA;
        end
        CHECK:
          if (w_acc) begin
            r_ready <= 1'b0;
            r_done  <= byte_data == r_xor;
            r_err   <= byte_data != r_xor;
            r_hold  <= byte_data != r_xor;
            r_state <= byte_data == r_xor ? DONE : ERR;
          end
        DONE, ERR:
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= LEN;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign byte_ready = r_ready;
  assign im_we      = r_we;
  assign im_waddr   = r_waddr;
  assign im_wdata   = r_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_cnt;
endmodule

// File: tb/tb_mips_im_loader.sv
// tb_mips_im_loader: directed + randomized loads checked against a byte-list model of the stream format.
module tb_mips_im_loader;
  typedef logic [7:0] bq_t[$];
  logic        clock, reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, im_we, cpu_hold, load_done, load_err;
  logic [7:0]  im_waddr;
  logic [31:0] im_wdata;
  logic [8:0]  word_count;
  int total = 0, bad = 0;
  logic [39:0] wq[$];
  mips_im_loader dut (
    .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clock)
    if (im_we === 1'b1) begin
      wq.push_back({im_waddr, im_wdata});
      chk("ready_in_write", byte_ready, 0);
    end
  task automatic pulse_start();
    start = 1;
    @(posedge clock); #1;
    start = 0;
  endtask
  task automatic send(input logic [7:0] b, input bit gaps);
    int n = gaps ? $urandom_range(0, 2) : 0;
    bit ok = 0;
    repeat (n) begin
      byte_valid = 0;
      @(posedge clock); #1;
    end
    byte_valid = 1;
    byte_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      if (byte_ready) begin
        @(posedge clock); #1;
        ok = 1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask
  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction
  task automatic do_load(input logic [7:0] len, input bq_t d, input int chk_ov, input bit gaps);
    logic [7:0] x = 0, c;
    int n = len == 0 ? 256 : int'(len);
    bit good;
    foreach (d[i]) x ^= d[i];
    c = chk_ov < 0 ? x : 8'(chk_ov);
    good = c == x;
    wq.delete();
    pulse_start();
    chk("ready_after_start", byte_ready, 1);
    send(len, gaps);
    foreach (d[i]) send(d[i], gaps);
    send(c, gaps);
    byte_valid = 0;
    chk("num_writes", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      chk("write", wq[i], {i[7:0], d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]});
    chk("load_done", load_done, good);
    chk("load_err", load_err, !good);
    chk("cpu_hold", cpu_hold, !good);
    chk("word_count", word_count, n);
    chk("ready_after_chk", byte_ready, 0);
  endtask
  initial begin
    bq_t d;
    reset = 1; start = 0; byte_valid = 0; byte_data = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {byte_ready, im_we, im_waddr, im_wdata, cpu_hold, load_done, load_err, word_count},
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 9'h0});
    reset = 0;
    @(posedge clock); #1;
    start = 0; byte_valid = 1;
    @(posedge clock); #1;
    chk("idle_ignores_bytes", byte_ready, 0);
    byte_valid = 0;
    d = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    do_load(8'd2, d, -1, 0);
    do_load(8'd2, d, 8'h00, 0);
    do_load(8'd0, rand_bytes(1024), -1, 0);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] len = 8'($urandom_range(1, 12));
      bq_t r = rand_bytes(4 * int'(len));
      do_load(len, r, (k % 3 == 2) ? int'(8'($urandom)) : -1, 1);
    end
    d = rand_bytes(12);
    wq.delete();
    pulse_start();
    send(8'd3, 0);
    for (int i = 0; i < 6; i++) send(d[i], 0);
    reset = 1;
    #1;
    chk("midload_reset_outputs", {byte_ready, im_we, im_waddr, im_wdata, cpu_hold, load_done, load_err, word_count},
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 9'h0});
    chk("midload_writes", wq.size(), 1);
    chk("midload_word0", wq[0], {8'h00, d[0], d[1], d[2], d[3]});
    byte_valid = 0;
    @(posedge clock); #1;
    reset = 0;
    do_load(8'd3, d, -1, 1);
    d = rand_bytes(4);
    wq.delete();
    pulse_start();
    send(8'd1, 0);
    send(d[0], 0);
    send(d[1], 0);
    byte_valid = 0;
    pulse_start();
    chk("start_in_data_ignored", {load_done, cpu_hold, byte_ready}, 3'b011);
    send(d[2], 0);
    send(d[3], 0);
    send(d[0] ^ d[1] ^ d[2] ^ d[3], 0);
    byte_valid = 0;
    chk("restart_word", wq.size() == 1 ? wq[0] : 40'h0, {8'h00, d[0], d[1], d[2], d[3]});
    chk("restart_done", {load_done, load_err, cpu_hold}, 3'b100);
    pulse_start();
    chk("start_in_done", {load_done, load_err, cpu_hold, byte_ready}, 4'b0011);
    do_load(8'd2, rand_bytes(8), -1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
